// File: rtl/vga_draw_ctrl.sv
// vga_draw_ctrl
//   Drawing controller placed in front of the vga pixel-write port. It
//   arbitrates between single-pixel CPU writes and a full-screen clear
//   engine. The clear engine sweeps every visible pixel in row-major order
//   using a fill colour latched when the clear starts. At most one registered
//   plot per clock is presented on x/y/colour/plot.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   pix_valid/ready     CPU pixel handshake; pix_x/pix_y/pix_colour payload
//   pix_drop            1-cycle pulse: accepted pixel was out of range
//   clr_req/clr_colour  clear request (sampled each cycle) and fill colour
//   busy                clear in progress
//   clr_done            1-cycle pulse when a clear completes
//   x, y, colour, plot  registered plot command to the vga block
module vga_draw_ctrl #(
    parameter int COLS = 136,
    parameter int ROWS = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] pix_x,
    input  logic [6:0] pix_y,
    input  logic [2:0] pix_colour,
    output logic       pix_drop,
    input  logic       clr_req,
    input  logic [2:0] clr_colour,
    output logic       busy,
    output logic       clr_done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [7:0] CX_LAST  = 8'(COLS - 1);
    localparam logic [6:0] CY_LAST  = 7'(ROWS - 1);
    localparam logic [8:0] COLS_LIM = 9'(COLS);
    localparam logic [7:0] ROWS_LIM = 8'(ROWS);

    state_t     state_q, state_d;
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
    logic [2:0] fill_q, fill_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       drop_q, drop_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       handshake;
    logic       in_range;

    assign pix_ready = !busy_q && !clr_req;
    assign handshake = pix_valid && pix_ready;
    assign in_range  = ({1'b0, pix_x} < COLS_LIM) && ({1'b0, pix_y} < ROWS_LIM);

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        fill_d   = fill_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        drop_d   = 1'b0;
        busy_d   = 1'b0;
        // The FSM returns to IDLE on the edge that registers the last
        // pixel; busy stays high one more cycle while that pixel is
        // presented, and its falling edge produces the done pulse.
        done_d   = busy_q && (state_q == IDLE);

        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                    fill_d  = clr_colour;
                    busy_d  = 1'b1;
                end else if (handshake) begin
                    if (in_range) begin
                        plot_d   = 1'b1;
                        x_d      = pix_x;
                        y_d      = pix_y;
                        colour_d = pix_colour;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                busy_d   = 1'b1;
                plot_d   = 1'b1;
                x_d      = cx_q;
                y_d      = cy_q;
                colour_d = fill_q;
                if (cx_q == CX_LAST) begin
                    cx_d = '0;
                    if (cy_q == CY_LAST) begin
                        cy_d    = '0;
                        state_d = IDLE;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cx_q     <= '0;
            cy_q     <= '0;
            fill_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            drop_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            fill_q   <= fill_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            drop_q   <= drop_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign colour   = colour_q;
    assign plot     = plot_q;
    assign pix_drop = drop_q;
    assign busy     = busy_q;
    assign clr_done = done_q;

endmodule
